// File: rtl/simplez_core.sv
// simplez_core: Simplez processor core with eight-instruction set plus WAIT.
// Runs from an external single-port RAM with a registered read (data is valid
// one cycle after the address is presented). One memory-mapped output register
// is located at IO_ADDR.
//
// Ports:
//   clk        system clock, rising edge
//   rstn_ini   asynchronous active-low reset
//   mem_addr   memory address, combinational from state
//   mem_wdata  memory write data (always the accumulator)
//   mem_we     memory write enable, the write happens at the rising edge
//   mem_rdata  memory read data, one cycle after mem_addr
//   io_out     output register written by ST to IO_ADDR
//   io_strobe  one-cycle pulse following an io_out update
//   acc        accumulator
//   zero       Z flag
//   stop       high once HALT has executed
module simplez_core #(
  parameter int unsigned AW         = 9,
  parameter int unsigned DW         = 12,
  parameter int unsigned WAIT_DELAY = 2400000,
  parameter int unsigned IO_ADDR    = 2**AW - 1
) (
  input  logic          clk,
  input  logic          rstn_ini,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] io_out,
  output logic          io_strobe,
  output logic [DW-1:0] acc,
  output logic          zero,
  output logic          stop
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC1, S_EXEC2, S_WAITING, S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    OP_ST, OP_LD, OP_ADD, OP_BR, OP_BZ, OP_CLR, OP_DEC, OP_EXT
  } op_t;

  localparam logic [AW-1:0] IO_CD     = AW'(IO_ADDR);
  localparam logic [31:0]   WAIT_LOAD = 32'(WAIT_DELAY - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] pc;
  logic [DW-1:0] ri;
  logic [31:0]   wcnt;

  op_t           op;
  logic [AW-1:0] cd;
  logic          is_wait;
  logic          st_io;
  logic [DW-1:0] acc_dec;
  logic [DW-1:0] acc_sum;
  logic          unused_ri;

  assign op        = op_t'(ri[DW-1 -: 3]);
  assign cd        = ri[AW-1:0];
  // extended opcodes are 0xE (HALT) and 0xF (WAIT): the low COE bit selects
  assign is_wait   = ri[DW-4];
  assign st_io     = (cd == IO_CD);
  assign acc_dec   = acc - DW'(1);
  assign acc_sum   = acc + mem_rdata;
  assign mem_wdata = acc;
  assign stop      = (state == S_HALTED);
  assign unused_ri = ^ri;

  always_ff @(posedge clk or negedge rstn_ini) begin
    if (!rstn_ini) state <= S_FETCH;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = pc;
    mem_we    = 1'b0;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC1;
      S_EXEC1: begin
        state_nxt = S_FETCH;
        case (op)
          OP_ST: begin
            mem_addr = cd;
            mem_we   = !st_io;
          end
          OP_LD, OP_ADD: begin
            mem_addr  = cd;
            state_nxt = S_EXEC2;
          end
          OP_EXT:  state_nxt = is_wait ? S_WAITING : S_HALTED;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_EXEC2:   state_nxt = S_FETCH;
      S_WAITING: if (wcnt == '0) state_nxt = S_FETCH;
      S_HALTED:  state_nxt = S_HALTED;
      default:   state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rstn_ini) begin
    if (!rstn_ini) begin
      pc        <= '0;
      ri        <= '0;
      acc       <= '0;
      zero      <= 1'b1;
      wcnt      <= '0;
      io_out    <= '0;
      io_strobe <= 1'b0;
    end else begin
      io_strobe <= 1'b0;
      case (state)
        S_DECODE: begin
          ri <= mem_rdata;
          pc <= pc + AW'(1);
        end
        S_EXEC1: begin
          case (op)
            OP_ST: if (st_io) begin
              io_out    <= acc;
              io_strobe <= 1'b1;
            end
            OP_BR:  pc <= cd;
            OP_BZ:  if (zero) pc <= cd;
            OP_CLR: begin
              acc  <= '0;
              zero <= 1'b1;
            end
            OP_DEC: begin
              acc  <= acc_dec;
              zero <= (acc_dec == '0);
            end
            OP_EXT: if (is_wait) wcnt <= WAIT_LOAD;
            default: ;
          endcase
        end
        // only LD and ADD reach EXEC2
        S_EXEC2: begin
          if (op == OP_LD) begin
            acc  <= mem_rdata;
            zero <= (mem_rdata == '0);
          end else begin
            acc  <= acc_sum;
            zero <= (acc_sum == '0);
          end
        end
        S_WAITING: if (wcnt != '0) wcnt <= wcnt - 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simplez_core.sv
// tb_simplez_core: directed checks of simplez_core with an AW=9/DW=12 core
// (WAIT_DELAY=4) and an AW=6/DW=10 core, each on a registered-read RAM model.
module tb_simplez_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int we_cnt_a = 0;
  int we_cnt_b = 0;

  // core A: AW=9, DW=12
  logic        rst_a;
  logic [8:0]  addr_a;
  logic [11:0] wdata_a, rdata_a, io_a, acc_a;
  logic        we_a, strobe_a, zero_a, stop_a;
  logic [11:0] mem_a [512];
  logic        clr_a, ld_en_a;
  logic [8:0]  ld_addr_a;
  logic [11:0] ld_data_a;

  // core B: AW=6, DW=10
  logic        rst_b;
  logic [5:0]  addr_b;
  logic [9:0]  wdata_b, rdata_b, io_b, acc_b;
  logic        we_b, strobe_b, zero_b, stop_b;
  logic [9:0]  mem_b [64];
  logic        clr_b, ld_en_b;
  logic [5:0]  ld_addr_b;
  logic [9:0]  ld_data_b;

  simplez_core #(.AW(9), .DW(12), .WAIT_DELAY(4), .IO_ADDR(511)) dut_a (
    .clk(clk), .rstn_ini(rst_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .mem_we(we_a), .mem_rdata(rdata_a), .io_out(io_a), .io_strobe(strobe_a),
    .acc(acc_a), .zero(zero_a), .stop(stop_a)
  );

  simplez_core #(.AW(6), .DW(10), .WAIT_DELAY(2), .IO_ADDR(63)) dut_b (
    .clk(clk), .rstn_ini(rst_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .mem_we(we_b), .mem_rdata(rdata_b), .io_out(io_b), .io_strobe(strobe_b),
    .acc(acc_b), .zero(zero_b), .stop(stop_b)
  );

  always @(posedge clk) begin
    if (clr_a) begin
      for (int i = 0; i < 512; i++) mem_a[i] <= '0;
    end else if (ld_en_a) mem_a[ld_addr_a] <= ld_data_a;
    else if (we_a)        mem_a[addr_a] <= wdata_a;
    rdata_a <= mem_a[addr_a];
  end

  always @(posedge clk) begin
    if (clr_b) begin
      for (int j = 0; j < 64; j++) mem_b[j] <= '0;
    end else if (ld_en_b) mem_b[ld_addr_b] <= ld_data_b;
    else if (we_b)        mem_b[addr_b] <= wdata_b;
    rdata_b <= mem_b[addr_b];
  end

  function automatic logic [11:0] ia(input int co, input int cd);
    return 12'((co << 9) | cd);
  endfunction

  function automatic logic [9:0] ib(input int co, input int cd);
    return 10'((co << 7) | cd);
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (we_a) we_cnt_a++;
    if (we_b) we_cnt_b++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_a();
    clr_a = 1'b1; tick(); clr_a = 1'b0;
  endtask

  task automatic load_a(input int a, input logic [11:0] d);
    ld_addr_a = 9'(a); ld_data_a = d; ld_en_a = 1'b1; tick(); ld_en_a = 1'b0;
  endtask

  task automatic load_b(input int a, input logic [9:0] d);
    ld_addr_b = 6'(a); ld_data_b = d; ld_en_b = 1'b1; tick(); ld_en_b = 1'b0;
  endtask

  task automatic release_a();
    rst_a = 1'b1; cyc = 0; we_cnt_a = 0; #1;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    clr_a = 1'b0; ld_en_a = 1'b0; ld_addr_a = '0; ld_data_a = '0;
    clr_b = 1'b0; ld_en_b = 1'b0; ld_addr_b = '0; ld_data_b = '0;
    tick(); tick();

    // reset values
    check("rst_acc",    32'(acc_a),    32'h0);
    check("rst_zero",   32'(zero_a),   32'h1);
    check("rst_stop",   32'(stop_a),   32'h0);
    check("rst_we",     32'(we_a),     32'h0);
    check("rst_addr",   32'(addr_a),   32'h0);
    check("rst_io",     32'(io_a),     32'h0);
    check("rst_strobe", 32'(strobe_a), 32'h0);

    // LD 16; ADD 17; HALT with 0x005 + 0xFFF
    clear_a();
    load_a(0, ia(1, 16));
    load_a(1, ia(2, 17));
    load_a(2, 12'hE00);
    load_a(16, 12'h005);
    load_a(17, 12'hFFF);
    release_a();
    check("p1_fetch0", 32'(addr_a), 32'h0);
    run_to(2);  check("p1_ld_addr", 32'(addr_a), 32'd16);
    run_to(3);  check("p1_ld_exec2_addr", 32'(addr_a), 32'd1);
    run_to(4);  check("p1_fetch1", 32'(addr_a), 32'd1);
                check("p1_ld_acc", 32'(acc_a), 32'h005);
                check("p1_ld_z", 32'(zero_a), 32'h0);
    run_to(8);  check("p1_fetch2", 32'(addr_a), 32'd2);
                check("p1_add_acc", 32'(acc_a), 32'h004);
                check("p1_add_z", 32'(zero_a), 32'h0);
    run_to(10); check("p1_stop_pre", 32'(stop_a), 32'h0);
    run_to(11); check("p1_stop", 32'(stop_a), 32'h1);
                check("p1_halt_addr", 32'(addr_a), 32'd3);

    // countdown: CLR; ADD 16; DEC; BZ 6; BR 2; HALT (HALT also at 6)
    rst_a = 1'b0;
    clear_a();
    load_a(0, ia(5, 0));
    load_a(1, ia(2, 16));
    load_a(2, ia(6, 0));
    load_a(3, ia(4, 6));
    load_a(4, ia(3, 2));
    load_a(5, 12'hE00);
    load_a(6, 12'hE00);
    load_a(16, 12'h005);
    release_a();
    run_to(7);  check("p2_add_acc", 32'(acc_a), 32'h005);
    run_to(16); check("p2_loop_addr", 32'(addr_a), 32'd2);
                check("p2_loop_acc", 32'(acc_a), 32'h004);
    run_to(49); check("p2_bz_target", 32'(addr_a), 32'd6);
    run_to(51); check("p2_stop_pre", 32'(stop_a), 32'h0);
    run_to(52); check("p2_stop", 32'(stop_a), 32'h1);
                check("p2_acc", 32'(acc_a), 32'h0);
                check("p2_z", 32'(zero_a), 32'h1);
                check("p2_halt_addr", 32'(addr_a), 32'd7);
    run_to(60); check("p2_no_we", 32'(we_cnt_a), 32'h0);
                check("p2_stop_hold", 32'(stop_a), 32'h1);

    // store/IO/WAIT: LD 16; ST 20; LD 20; ST 511; WAIT; ADD 17; HALT
    rst_a = 1'b0;
    clear_a();
    load_a(0, ia(1, 16));
    load_a(1, ia(0, 20));
    load_a(2, ia(1, 20));
    load_a(3, ia(0, 511));
    load_a(4, 12'hF00);
    load_a(5, ia(2, 17));
    load_a(6, 12'hE00);
    load_a(16, 12'h0A5);
    load_a(17, 12'h001);
    load_a(20, 12'h123);
    release_a();
    run_to(5);  check("p3_we_pre", 32'(we_a), 32'h0);
    run_to(6);  check("p3_st_we", 32'(we_a), 32'h1);
                check("p3_st_addr", 32'(addr_a), 32'd20);
                check("p3_st_wdata", 32'(wdata_a), 32'h0A5);
    run_to(7);  check("p3_we_post", 32'(we_a), 32'h0);
    run_to(11); check("p3_ld20_acc", 32'(acc_a), 32'h0A5);
    run_to(13); check("p3_io_we", 32'(we_a), 32'h0);
                check("p3_strobe_pre", 32'(strobe_a), 32'h0);
    run_to(14); check("p3_strobe", 32'(strobe_a), 32'h1);
                check("p3_io_out", 32'(io_a), 32'h0A5);
    run_to(15); check("p3_strobe_post", 32'(strobe_a), 32'h0);
    run_to(21); check("p3_wait_acc", 32'(acc_a), 32'h0A5);
                check("p3_wait_z", 32'(zero_a), 32'h0);
                check("p3_we_count", 32'(we_cnt_a), 32'h1);
    run_to(22); check("p3_wait_decode", 32'(addr_a), 32'd5);
    run_to(23); check("p3_wait_exec1", 32'(addr_a), 32'd17);
    run_to(24);
    // asynchronous reset in EXEC2 of ADD
    rst_a = 1'b0; #1;
    check("ar_we", 32'(we_a), 32'h0);
    check("ar_acc", 32'(acc_a), 32'h0);
    check("ar_stop", 32'(stop_a), 32'h0);
    check("ar_addr", 32'(addr_a), 32'h0);
    check("ar_z", 32'(zero_a), 32'h1);
    tick(); tick();
    release_a();
    check("ar_fetch0", 32'(addr_a), 32'h0);
    run_to(2);  check("ar_restart", 32'(addr_a), 32'd16);
    rst_a = 1'b0;

    // core B: LD 16; ADD 17; ST 20; LD 20; ST 63; BR 63; [63] DEC
    clr_b = 1'b1; tick(); clr_b = 1'b0;
    load_b(0, ib(1, 16));
    load_b(1, ib(2, 17));
    load_b(2, ib(0, 20));
    load_b(3, ib(1, 20));
    load_b(4, ib(0, 63));
    load_b(5, ib(3, 63));
    load_b(63, ib(6, 0));
    load_b(16, 10'h005);
    load_b(17, 10'h3FF);
    load_b(20, 10'h123);
    rst_b = 1'b1; cyc = 0; we_cnt_b = 0; #1;
    check("b_fetch0", 32'(addr_b), 32'h0);
    run_to(4);  check("b_ld_acc", 32'(acc_b), 32'h005);
    run_to(8);  check("b_add_acc", 32'(acc_b), 32'h004);
                check("b_add_z", 32'(zero_b), 32'h0);
                check("b_fetch2", 32'(addr_b), 32'd2);
    run_to(10); check("b_st_we", 32'(we_b), 32'h1);
                check("b_st_addr", 32'(addr_b), 32'd20);
                check("b_st_wdata", 32'(wdata_b), 32'h004);
    run_to(11); check("b_we_post", 32'(we_b), 32'h0);
    run_to(15); check("b_ld20_acc", 32'(acc_b), 32'h004);
    run_to(17); check("b_io_we", 32'(we_b), 32'h0);
    run_to(18); check("b_strobe", 32'(strobe_b), 32'h1);
                check("b_io_out", 32'(io_b), 32'h004);
    run_to(19); check("b_strobe_post", 32'(strobe_b), 32'h0);
    run_to(21); check("b_br63", 32'(addr_b), 32'd63);
    run_to(24); check("b_wrap_fetch", 32'(addr_b), 32'h0);
                check("b_dec_acc", 32'(acc_b), 32'h003);
                check("b_we_count", 32'(we_cnt_b), 32'h1);
                check("b_stop", 32'(stop_b), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simplez_core.md
# simplez_core

Parametrised Simplez processor core with the full eight-instruction set (ST, LD, ADD, BR, BZ, CLR, DEC, HALT) plus the WAIT extension. It drives an external synchronous read/write memory, has a zero flag, and has one memory-mapped output register. It replaces the ROM-only LD/BR/HALT/WAIT sequencer and sits between the board top level (LEDs, stop indicator) and a generic single-port RAM.

## Interface
Parameters:
- AW, 9, address width; also the CD field width.
- DW, 12, data and instruction width; must satisfy DW >= AW+3.
- WAIT_DELAY, 2400000, clock cycles spent in the WAIT state; must be >= 1.
- IO_ADDR, 2**AW-1, address of the memory-mapped output register.

Ports:
- clk  in  1  system clock, rising edge.
- rstn_ini  in  1  reset; one clock, asynchronous and active-low.
- mem_addr  out  AW  memory address (combinational from state).
- mem_wdata  out  DW  write data; equals acc.
- mem_we  out  1  write enable; the write occurs at the rising edge.
- mem_rdata  in  DW  read data; valid one cycle after mem_addr (registered read).
- io_out  out  DW  output register written by ST to IO_ADDR.
- io_strobe  out  1  one-cycle pulse after io_out updates.
- acc  out  DW  accumulator (the board top level drives the LEDs from acc[3:0]).
- zero  out  1  Z flag.
- stop  out  1  high once HALT has executed.

## Operation
- Instruction word fields:
  - CO = [DW-1:DW-3].
  - COE = [DW-1:DW-4].
  - CD = [AW-1:0].
  - Remaining bits are ignored.
- Opcodes (CO): ST=0, LD=1, ADD=2, BR=3, BZ=4, CLR=5, DEC=6, 7=extended.
- Extended opcodes (COE): 0xE=HALT, 0xF=WAIT.
- Registers: pc (AW), ri (DW), acc (DW), z, wait counter (32 bit), io_out, io_strobe, state.
- Reset values: pc=0, ri=0, acc=0, z=1, io_out=0, io_strobe=0, stop=0, state=FETCH.
- Reset is asynchronous and may arrive in any state. While rstn_ini is low: mem_we=0 and mem_addr=0.
- Arithmetic is modulo 2^DW. ADD wraps. DEC of 0 gives all-ones with z=0.
- z is written only by LD, ADD, CLR and DEC: z = (new acc == 0). ST, BR, BZ and WAIT leave z unchanged.
- States and transitions:
  - FETCH: mem_addr=pc. Next state DECODE.
  - DECODE: ri <= mem_rdata; pc <= pc+1 (wraps at 2^AW). Next state EXEC1.
  - EXEC1, by opcode:
    - ST, CD != IO_ADDR: mem_addr=CD, mem_we=1. Next FETCH.
    - ST, CD == IO_ADDR: mem_we=0; io_out <= acc; io_strobe <= 1. Next FETCH.
    - LD / ADD: mem_addr=CD. Next EXEC2.
    - BR: pc <= CD. Next FETCH.
    - BZ: if z, pc <= CD, otherwise pc is unchanged. Next FETCH.
    - CLR: acc <= 0. Next FETCH.
    - DEC: acc <= acc-1. Next FETCH.
    - HALT: next HALTED.
    - WAIT: counter <= WAIT_DELAY-1. Next WAITING.
  - EXEC2:
    - LD: acc <= mem_rdata.
    - ADD: acc <= acc + mem_rdata.
    - Next FETCH.
  - WAITING: if counter==0, next FETCH; otherwise counter decrements.
  - HALTED: terminal until reset. stop=1, mem_we=0, mem_addr=pc.
- mem_we is asserted only in EXEC1 of an ST whose CD != IO_ADDR.
- io_strobe is high for exactly one cycle: the cycle after that EXEC1.
- LD or ADD from IO_ADDR reads memory normally. There is no input port.

## Timing
- Cycles per instruction, counted from its FETCH cycle to the next FETCH:
  - ST, BR, BZ, CLR, DEC: 3.
  - LD, ADD: 4.
  - WAIT: 3 + WAIT_DELAY.
- First FETCH of address 0 is in the first clock cycle after rstn_ini deasserts.
- A memory write is visible to an LD whose FETCH is the next cycle.
- stop rises on the first edge after EXEC1 of HALT, i.e. 3 cycles after that HALT's FETCH.
- Self-loops: BR to its own address loops every 3 cycles. BZ with z=0 falls through to pc+1.
- pc wrap: an instruction at address 2^AW-1 is followed by a fetch from address 0.

## Test plan
- Reset: run a program, pull rstn_ini low during EXEC2 of an ADD.
  - Required: mem_we=0 and acc=0 immediately; stop=0; after release, mem_addr=0 in FETCH.
- Load/add wrap (AW=9, DW=12; mem[16]=0x005, mem[17]=0xFFF): program LD 16; ADD 17.
  - Required: acc=0x004, z=0. LD takes 4 cycles.
- Countdown loop: CLR; ADD 16; DEC; BZ 6; BR 2; HALT.
  - Required: HALT is reached after 5 DECs; stop=1; acc=0; no mem_we pulse at any time.
- Store and IO (acc=0x0A5):
  - ST 20 followed by LD 20 -> mem_we=1 for one cycle with mem_addr=20 and mem_wdata=0x0A5; acc=0x0A5.
  - ST 511 -> io_out=0x0A5, io_strobe high for exactly 1 cycle, mem_we stays 0.
- WAIT with WAIT_DELAY=4:
  - Required: the next FETCH occurs exactly 7 cycles after the WAIT's FETCH; acc and z are unchanged.
- Second instance with AW=6, DW=10, IO_ADDR=63: repeat the load/add and store/IO scenarios.
  - Required: ADD wraps at 0x3FF; BR to CD=63 loads pc=63; the next fetch after address 63 is from address 0.
